// File: rtl/reduceadd_arbiter.sv
// ReduceAdd arbiter: two requesters share one signed accumulator.
// The winner streams cfg_size elements, and the sum is then presented
// on a valid/ready result port.
module reduceadd_arbiter #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CNT_WIDTH-1:0] cfg_size,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_data,
    output logic                 req1_ready,
    output logic                 res_valid,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_grant;
    logic                 r_last;
    logic [CNT_WIDTH-1:0] r_size;
    logic [CNT_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_resData;
    logic                 r_resId;

    logic                 w_anyReq;
    logic                 w_pick;
    logic [CNT_WIDTH-1:0] w_effSize;
    logic                 w_grantValid;
    logic [WIDTH-1:0]     w_grantData;
    logic                 w_xfer;
    logic                 w_lastXfer;
    logic [WIDTH-1:0]     w_sum;

    // On a tie, the requester that was not served last wins. Otherwise the
    // only active requester wins.
    assign w_anyReq     = req0_valid | req1_valid;
    assign w_pick       = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_effSize    = (cfg_size == '0) ? ONE : cfg_size;
    assign w_grantValid = r_grant ? req1_valid : req0_valid;
    assign w_grantData  = r_grant ? req1_data : req0_data;
    assign w_xfer       = (r_state == ACCUM) & w_grantValid;
    assign w_lastXfer   = w_xfer & (r_count == (r_size - ONE));
    assign w_sum        = r_acc + w_grantData;

    // Update the state register; reset returns the FSM to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Compute the next state from the current state, the requests,
    // accepted elements and result acceptance.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq)   w_nextState = ACCUM;
            ACCUM:   if (w_lastXfer) w_nextState = DONE;
            DONE:    if (res_ready)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Drive the handshake outputs from the state.
    // Only the granted requester sees a ready.
    always_comb begin
        req0_ready = (r_state == ACCUM) & ~r_grant;
        req1_ready = (r_state == ACCUM) & r_grant;
        res_valid  = (r_state == DONE);
        busy       = (r_state != IDLE);
    end

    assign res_data = r_resData;
    assign res_id   = r_resId;

    // Datapath: grant and size latch, wrapping accumulation, result capture,
    // and recording the last-served requester.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_size    <= '0;
            r_count   <= '0;
            r_acc     <= '0;
            r_resData <= '0;
            r_resId   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant <= w_pick;
                        r_size  <= w_effSize;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + ONE;
                        if (w_lastXfer) begin
                            r_resData <= w_sum;
                            r_resId   <= r_grant;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_last <= r_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
